letc_core_csr_counters: RTL and testbench
=========================================

// Module: letc_core_csr_counters
// PURPOSE
// - Machine/user performance counters for the LETC core: mcycle, minstret, mcountinhibit,
//   their user-mode read-only aliases, and optionally hpmcounter3.
// - Sits beside the CSR file in the core. It consumes the same explicit read/write index
//   stream and the per-cycle retire strobe from WB.
// - It produces read data plus a hit flag, which the CSR file muxes into its explicit read data.
// PARAMETERS
// - CNT_WIDTH    64   counter width in bits; legal range 33..64; bits >= CNT_WIDTH read as 0
// PORTS
// - clk                  in   1   core clock; only clock
// - rst_n                in   1   asynchronous active-low reset
// - instr_retired        in   1   one instruction retired this cycle (WB commit strobe)
// - hpm_event            in   1   stall event for hpmcounter3 (ignored unless feature built in)
// - csr_explicit_ren     in   1   explicit read enable
// - csr_explicit_ridx    in   12  csr_idx_t read index
// - csr_explicit_rdata   out  32  read data; 0 when no hit
// - csr_explicit_rhit    out  1   ridx decodes to a CSR owned by this block and ren is high
// - csr_explicit_wen     in   1   explicit write enable (legality already checked in ID)
// - csr_explicit_widx    in   12  csr_idx_t write index
// - csr_explicit_wdata   in   32  write data
// BEHAVIOUR
// - Reset: all counters and mcountinhibit are 0; rdata is 0; rhit is 0.
// - Read path: combinational from registered state, giving the value before this cycle's
//   update. rdata is 0 and rhit is 0 when ren is 0.
// - Decoded CSRs:
//   - mcycle B00, mcycleh B80, minstret B02, minstreth B82, mcountinhibit 320.
//   - Read-only aliases: cycle C00, cycleh C80, instret C02, instreth C82.
//   - Writes to the aliases are ignored here; illegality is flagged upstream.
// - mcountinhibit: bit0 CY and bit2 IR are writable. All other bits write-ignored, read 0.
//   bit1 (TM) reads 0.
// - mcycle increments by 1 every cycle when CY=0.
// - minstret increments by 1 on each cycle with instr_retired=1 when IR=0.
// - Explicit write to a counter, same cycle:
//   - A write to the low half sets low[31:0]=wdata; the high half keeps its old value
//     (no carry).
//   - A write to the high half sets high=wdata[CNT_WIDTH-33:0]; the low half keeps its old
//     value.
//   - The write wins: that counter does not increment in that cycle. The other counter is
//     unaffected.
//   - Writing minstret in the same cycle the writing CSR instruction retires: the written
//     value is kept, with no +1.
// - Writing mcountinhibit takes effect for increments starting the next cycle. The write
//   cycle uses the old inhibit bits.
// - Wrap-around: all-ones + 1 -> 0, silently, with no flag.
// - Latency: write/increment visible on the read port 1 cycle later.
// - Reset asserted mid-operation: all state returns to 0 immediately (async). The first
//   increment happens on the first clk edge after deassertion.
// - No handshake: single-cycle accept; wen is never back-pressured.
// CONFIGURATION
// - LETC_CORE_HPMCOUNTER3_EN defined:
//   - Adds mhpmcounter3 B03/B83, alias hpmcounter3 C03/C83, and mcountinhibit bit3 (HPM3).
//   - The counter increments on hpm_event when HPM3=0, with the same write/wrap rules as
//     above.
// - Not defined: those indices give rhit=0; bit3 reads 0 and ignores writes; hpm_event is
//   unused.
// STRUCTURE
// - letc_core_pkg:
//   - CSR_IDX_* constants for every index above.
//   - MCOUNTINHIBIT_CY/IR/HPM3 bit positions.
//   - cnt_t typedef logic [63:0].
// - Sub-module letc_core_csr_counter: one CNT_WIDTH counter with inc, wen_lo, wen_hi, wdata
//   and value out. Instantiated 2x, or 3x with the feature built in.
// - Top level: index decode, mcountinhibit register, read mux.
// TESTING
// - Reset, then 10 idle cycles; read mcycle -> 10, mcycleh -> 0, minstret -> 0, rhit=1.
// - instr_retired high 5 cycles; read minstret -> 5 and instret (C02) -> 5.
// - Write mcountinhibit=0xFFFF_FFFF; read it back -> 0x5 (0xD with HPM3 built in).
//   mcycle holds its value for 20 cycles.
// - Write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF; next cycle read mcycle -> 0 and
//   mcycleh -> 0 (wrap).
// - Write minstret=0x100 with instr_retired=1 in the same cycle; next read -> 0x100.
//   Write C02=0x55 -> minstret unchanged.
// - Assert rst_n low mid-count, asynchronous to clk; all reads -> 0.
//   With the feature built out, read 0xB03 -> rhit=0, rdata=0.

Source files
------------

// File: rtl/letc_core_pkg.sv
// rtl/letc_core_pkg.sv - CSR indices, mcountinhibit bit positions and counter types for the LETC core
package letc_core_pkg;

    typedef logic [11:0] csr_idx_t;
    typedef logic [63:0] cnt_t;

    localparam csr_idx_t CSR_IDX_MCOUNTINHIBIT = 12'h320;
    localparam csr_idx_t CSR_IDX_MCYCLE        = 12'hB00;
    localparam csr_idx_t CSR_IDX_MINSTRET      = 12'hB02;
    localparam csr_idx_t CSR_IDX_MHPMCOUNTER3  = 12'hB03;
    localparam csr_idx_t CSR_IDX_MCYCLEH       = 12'hB80;
    localparam csr_idx_t CSR_IDX_MINSTRETH     = 12'hB82;
    localparam csr_idx_t CSR_IDX_MHPMCOUNTER3H = 12'hB83;
    localparam csr_idx_t CSR_IDX_CYCLE         = 12'hC00;
    localparam csr_idx_t CSR_IDX_INSTRET       = 12'hC02;
    localparam csr_idx_t CSR_IDX_HPMCOUNTER3   = 12'hC03;
    localparam csr_idx_t CSR_IDX_CYCLEH        = 12'hC80;
    localparam csr_idx_t CSR_IDX_INSTRETH      = 12'hC82;
    localparam csr_idx_t CSR_IDX_HPMCOUNTER3H  = 12'hC83;

    localparam int MCOUNTINHIBIT_CY   = 0;
    localparam int MCOUNTINHIBIT_IR   = 2;
    localparam int MCOUNTINHIBIT_HPM3 = 3;

endpackage

// File: rtl/letc_core_csr_counter.sv
// rtl/letc_core_csr_counter.sv - one CNT_WIDTH performance counter with split 32-bit half writes
module letc_core_csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 wen_lo,
    input  logic                 wen_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] r_value;

    // A write to either half suppresses that cycle's increment; the other half is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (wen_lo) begin
            r_value[31:0] <= wdata;
        end else if (wen_hi) begin
            r_value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
        end else if (inc) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/letc_core_csr_counters.sv
// rtl/letc_core_csr_counters.sv - mcycle/minstret/mcountinhibit CSRs and user aliases
// Optional mhpmcounter3/hpmcounter3 and mcountinhibit.HPM3 built in with LETC_CORE_HPMCOUNTER3_EN.
module letc_core_csr_counters
    import letc_core_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_retired,
    input  logic        hpm_event,
    input  logic        csr_explicit_ren,
    input  logic [11:0] csr_explicit_ridx,
    output logic [31:0] csr_explicit_rdata,
    output logic        csr_explicit_rhit,
    input  logic        csr_explicit_wen,
    input  logic [11:0] csr_explicit_widx,
    input  logic [31:0] csr_explicit_wdata
);

`ifdef LETC_CORE_HPMCOUNTER3_EN
    localparam logic [31:0] INHIBIT_MASK = 32'h0000_000D;
`else
    localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005;
`endif

    logic [31:0]          r_mcountinhibit;
    logic [CNT_WIDTH-1:0] w_cycle;
    logic [CNT_WIDTH-1:0] w_instret;
    cnt_t                 w_cycle64;
    cnt_t                 w_instret64;

    logic w_wen_cyc_lo;
    logic w_wen_cyc_hi;
    logic w_wen_ir_lo;
    logic w_wen_ir_hi;
    logic w_wen_inh;

    // Aliases (Cxx) are read-only here; only the machine indices decode as writes.
    assign w_wen_cyc_lo = csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MCYCLE);
    assign w_wen_cyc_hi = csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MCYCLEH);
    assign w_wen_ir_lo  = csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MINSTRET);
    assign w_wen_ir_hi  = csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MINSTRETH);
    assign w_wen_inh    = csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MCOUNTINHIBIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcountinhibit <= '0;
        end else if (w_wen_inh) begin
            r_mcountinhibit <= csr_explicit_wdata & INHIBIT_MASK;
        end
    end

    letc_core_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (!r_mcountinhibit[MCOUNTINHIBIT_CY]),
        .wen_lo (w_wen_cyc_lo),
        .wen_hi (w_wen_cyc_hi),
        .wdata  (csr_explicit_wdata),
        .value  (w_cycle)
    );

    letc_core_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (instr_retired && !r_mcountinhibit[MCOUNTINHIBIT_IR]),
        .wen_lo (w_wen_ir_lo),
        .wen_hi (w_wen_ir_hi),
        .wdata  (csr_explicit_wdata),
        .value  (w_instret)
    );

    assign w_cycle64   = cnt_t'(w_cycle);
    assign w_instret64 = cnt_t'(w_instret);

`ifdef LETC_CORE_HPMCOUNTER3_EN
    logic [CNT_WIDTH-1:0] w_hpm3;
    cnt_t                 w_hpm3_64;

    letc_core_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mhpmcounter3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (hpm_event && !r_mcountinhibit[MCOUNTINHIBIT_HPM3]),
        .wen_lo (csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MHPMCOUNTER3)),
        .wen_hi (csr_explicit_wen && (csr_explicit_widx == CSR_IDX_MHPMCOUNTER3H)),
        .wdata  (csr_explicit_wdata),
        .value  (w_hpm3)
    );

    assign w_hpm3_64 = cnt_t'(w_hpm3);
`else
    logic w_unused_hpm_event;
    assign w_unused_hpm_event = hpm_event;
`endif

    always_comb begin
        csr_explicit_rdata = '0;
        csr_explicit_rhit  = 1'b0;
        if (csr_explicit_ren) begin
            csr_explicit_rhit = 1'b1;
            case (csr_explicit_ridx)
                CSR_IDX_MCYCLE,    CSR_IDX_CYCLE:    csr_explicit_rdata = w_cycle64[31:0];
                CSR_IDX_MCYCLEH,   CSR_IDX_CYCLEH:   csr_explicit_rdata = w_cycle64[63:32];
                CSR_IDX_MINSTRET,  CSR_IDX_INSTRET:  csr_explicit_rdata = w_instret64[31:0];
                CSR_IDX_MINSTRETH, CSR_IDX_INSTRETH: csr_explicit_rdata = w_instret64[63:32];
                CSR_IDX_MCOUNTINHIBIT:               csr_explicit_rdata = r_mcountinhibit;
`ifdef LETC_CORE_HPMCOUNTER3_EN
                CSR_IDX_MHPMCOUNTER3,  CSR_IDX_HPMCOUNTER3:  csr_explicit_rdata = w_hpm3_64[31:0];
                CSR_IDX_MHPMCOUNTER3H, CSR_IDX_HPMCOUNTER3H: csr_explicit_rdata = w_hpm3_64[63:32];
`endif
                default: csr_explicit_rhit = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_letc_core_csr_counters.sv
// tb/tb_letc_core_csr_counters.sv - scoreboard bench for letc_core_csr_counters
module tb_letc_core_csr_counters;
    import letc_core_pkg::*;

`ifdef LETC_CORE_HPMCOUNTER3_EN
    localparam logic [31:0] MASK = 32'h0000_000D;
`else
    localparam logic [31:0] MASK = 32'h0000_0005;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_retired = 1'b0;
    logic        hpm_event = 1'b0;
    logic        ren = 1'b0;
    logic [11:0] ridx = '0;
    logic [31:0] rdata;
    logic        rhit;
    logic        wen = 1'b0;
    logic [11:0] widx = '0;
    logic [31:0] wdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        string       name;
    } exp_t;
    exp_t sb[$];

    logic [63:0] m_cyc;
    logic [63:0] m_ir;
    logic [31:0] m_inh;

    letc_core_csr_counters #(.CNT_WIDTH(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr_retired      (instr_retired),
        .hpm_event          (hpm_event),
        .csr_explicit_ren   (ren),
        .csr_explicit_ridx  (ridx),
        .csr_explicit_rdata (rdata),
        .csr_explicit_rhit  (rhit),
        .csr_explicit_wen   (wen),
        .csr_explicit_widx  (widx),
        .csr_explicit_wdata (wdata)
    );

    always #5 clk = ~clk;

    // Reference model of the architectural counter state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= '0;
            m_ir  <= '0;
            m_inh <= '0;
        end else begin
            if (wen && widx == 12'hB00)      m_cyc[31:0]  <= wdata;
            else if (wen && widx == 12'hB80) m_cyc[63:32] <= wdata;
            else if (!m_inh[0])              m_cyc <= m_cyc + 64'd1;
            if (wen && widx == 12'hB02)      m_ir[31:0]   <= wdata;
            else if (wen && widx == 12'hB82) m_ir[63:32]  <= wdata;
            else if (instr_retired && !m_inh[2]) m_ir <= m_ir + 64'd1;
            if (wen && widx == 12'h320)      m_inh <= wdata & MASK;
        end
    end

    function automatic logic [32:0] model_read(input logic [11:0] idx);
        case (idx)
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ir[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ir[63:32]};
            12'h320:          return {1'b1, m_inh};
`ifdef LETC_CORE_HPMCOUNTER3_EN
            12'hB03, 12'hB83, 12'hC03, 12'hC83: return {1'b1, 32'h0};
`endif
            default:          return 33'h0;
        endcase
    endfunction

    task automatic rd(input logic [11:0] idx, input logic [31:0] exp_data, input logic exp_hit,
                      input string nm, input logic use_model = 1'b0, input logic en = 1'b1);
        exp_t e;
        logic [32:0] m;
        @(negedge clk);
        ren  = en;
        ridx = idx;
        m = model_read(idx);
        if (use_model) sb.push_back('{m[31:0], m[32], nm});
        else           sb.push_back('{exp_data, exp_hit, nm});
        #2;
        e = sb.pop_front();
        checks++;
        if (rdata !== e.data || rhit !== e.hit) begin
            failures++;
            $display("FAIL %s: got rdata=%h rhit=%b, expected rdata=%h rhit=%b",
                     e.name, rdata, rhit, e.data, e.hit);
        end
        ren = 1'b0;
    endtask

    task automatic wr(input logic [11:0] idx, input logic [31:0] d, input logic ret = 1'b0);
        @(negedge clk);
        wen = 1'b1;
        widx = idx;
        wdata = d;
        instr_retired = ret;
        @(posedge clk);
        #1;
        wen = 1'b0;
        instr_retired = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        rd(12'hB00, 32'h0, 1'b1, "reset_mcycle");
        rd(12'h320, 32'h0, 1'b1, "reset_inhibit");
        rd(12'hB00, 32'h0, 1'b0, "reset_ren_low", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_count;
        repeat (10) @(posedge clk);
        rd(12'hB00, 32'd10, 1'b1, "idle_mcycle_10");
        rd(12'hB80, 32'd0, 1'b1, "idle_mcycleh_0");
        rd(12'hB02, 32'd0, 1'b1, "idle_minstret_0");
        rd(12'hC00, 32'd0, 1'b0, "ren_low_no_hit", 1'b0, 1'b0);
        rd(12'h123, 32'd0, 1'b0, "unmapped_no_hit");
    endtask

    task automatic test_retire;
        @(negedge clk);
        instr_retired = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        instr_retired = 1'b0;
        rd(12'hB02, 32'd5, 1'b1, "minstret_5");
        rd(12'hC02, 32'd5, 1'b1, "instret_alias_5");
    endtask

    task automatic test_inhibit;
        logic [32:0] held;
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, MASK, 1'b1, "inhibit_readback");
        rd(12'hB00, 32'h0, 1'b1, "inhibit_mcycle_a", 1'b1);
        held = model_read(12'hB00);
        @(negedge clk);
        instr_retired = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        instr_retired = 1'b0;
        rd(12'hB00, held[31:0], 1'b1, "inhibit_mcycle_held");
        rd(12'hB02, 32'd5, 1'b1, "inhibit_minstret_held");
        wr(12'h320, 32'h0);
        rd(12'h320, 32'h0, 1'b1, "inhibit_cleared");
    endtask

    task automatic test_wrap;
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80, 32'hFFFF_FFFF, 1'b1, "wrap_high_written");
        rd(12'hB00, 32'h0, 1'b1, "wrap_mcycle_0");
        rd(12'hB80, 32'h0, 1'b1, "wrap_mcycleh_0");
    endtask

    task automatic test_write_wins;
        wr(12'hB02, 32'h100, 1'b1);
        rd(12'hB02, 32'h100, 1'b1, "minstret_write_wins");
        wr(12'hC02, 32'h55);
        rd(12'hB02, 32'h100, 1'b1, "alias_write_ignored");
        wr(12'hB82, 32'h7);
        rd(12'hB82, 32'h7, 1'b1, "minstreth_written");
        rd(12'hB02, 32'h100, 1'b1, "minstret_low_kept");
    endtask

    task automatic test_back_to_back;
        logic [11:0] idx_tab [6];
        idx_tab = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02};
        for (int i = 0; i < 8; i++) begin
            wr(idx_tab[$urandom_range(0, 5)], $urandom, 1'($urandom_range(0, 1)));
            rd(idx_tab[$urandom_range(0, 5)], 32'h0, 1'b0, "random_read", 1'b1);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rd(12'hB00, 32'h0, 1'b1, "areset_mcycle");
        rd(12'hB80, 32'h0, 1'b1, "areset_mcycleh");
        rd(12'hB02, 32'h0, 1'b1, "areset_minstret");
        rd(12'hB82, 32'h0, 1'b1, "areset_minstreth");
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'hB00, 32'd1, 1'b1, "first_inc_after_reset");
`ifdef LETC_CORE_HPMCOUNTER3_EN
        rd(12'hB03, 32'h0, 1'b1, "hpm3_present");
`else
        rd(12'hB03, 32'h0, 1'b0, "hpm3_absent");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_count();
        test_retire();
        test_inhibit();
        test_wrap();
        test_write_wins();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
